load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the execute ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Runs byte/halfword/word loads and stores over a valid/ready data-memory port, and returns sign- or zero-extended load data to writeback.
- Stalls the pipeline while an access is outstanding; flags misaligned or illegal accesses instead of issuing them.

Parameters:
DATAWIDTH, 32, data/address width; only 32 is supported (4 byte lanes).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
MemRead_i  input  1  load requested by the instruction in this stage
MemWrite_i  input  1  store requested by the instruction in this stage
Funct3_i  input  3  RV32I load/store funct3
ALUResult_i  input  DATAWIDTH  effective byte address
WriteData_i  input  DATAWIDTH  store data (rs2)
mem_req_o  output  1  request valid
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  DATAWIDTH  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  output  DATAWIDTH  lane-replicated store data
mem_be_o  output  4  byte enables
mem_gnt_i  input  1  memory accepts request (ready)
mem_rvalid_i  input  1  read data valid
mem_rdata_i  input  DATAWIDTH  read word
ReadData_o  output  DATAWIDTH  extended load result
Stall_o  output  1  hold upstream pipeline
Done_o  output  1  one-cycle completion pulse
Fault_o  output  1  one-cycle misaligned/illegal pulse (coincident with Done_o)

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including ReadData_o. mem_req_o drops immediately mid-transaction. An rvalid arriving after reset is ignored.
- FSM states and transitions:
  - IDLE -> REQ on MemRead_i^MemWrite_i with a legal access. Address, funct3, data and direction are registered in that cycle.
  - IDLE -> DONE with a fault when the access is illegal (fault conditions below).
  - MemRead_i&MemWrite_i both high is illegal and faults.
  - REQ: mem_req_o=1, all request fields stable until mem_gnt_i. On gnt, a write goes to DONE and a read goes to WAIT.
  - WAIT: mem_req_o=0. On mem_rvalid_i, capture the extended data into ReadData_o and go to DONE. rvalid is guaranteed at least one cycle after gnt; rvalid in REQ or IDLE is ignored.
  - DONE: Done_o=1, Stall_o=0. Always returns to IDLE.
- Stall_o (combinational): 1 in REQ and WAIT; also 1 in IDLE when a legal or illegal access is presented; 0 in DONE. The pipeline advances at the DONE-cycle edge, so the IDLE cycle that follows sees the next instruction.
- Latency with zero-wait memory:
  - Store: accept cycle 0, request cycle 1 (gnt), Done cycle 2.
  - Load: gnt cycle 1, rvalid cycle 2, Done cycle 3.
  - No back-to-back overlap: one outstanding access maximum.
- Fault conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 > 010.
  - Effect: no memory request, DONE next cycle with Fault_o=1, ReadData_o unchanged.
- Store lanes, with o = addr[1:0]:
  - SB: be = 4'b0001<<o, wdata = {4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: be = 1111, wdata = data.
- Load lanes:
  - LB/LBU: select byte o, then sign-/zero-extend.
  - LH/LHU: select half addr[1], then sign-/zero-extend.
  - LW: whole word.
  - Reads drive mem_be_o=1111.
- ReadData_o holds its value until the next successful load completes; stores and faults leave it unchanged.
- Unbounded gnt/rvalid wait: remain in REQ/WAIT with Stall_o=1. There is no timeout.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - State enum {IDLE, REQ, WAIT, DONE}.
- One combinational sub-module load_extend (funct3, offset, rdata -> extended word). It is reused by the writeback bench model.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt in first REQ cycle -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF, Done on cycle 2, Stall high cycles 0-1.
- SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr 0x202, rdata 0x12F03456 -> ReadData_o=0xFFFFFFF0; LBU same access -> 0x000000F0; LHU addr 0x202 -> 0x000012F0.
- LW addr 0x300 with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> request fields stable throughout, Stall high until DONE, single Done pulse, ReadData_o=rdata.
- LH addr 0x101 and SW addr 0x102 -> no mem_req_o, Fault_o and Done_o pulse on cycle 1, ReadData_o unchanged.
- rst asserted in WAIT, then rvalid pulsed after release -> outputs 0 immediately, state IDLE, rvalid ignored, ReadData_o stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared funct3 encodings, FSM states and access-legality helper
//           for the load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam int LSU_WIDTH = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Exactly one of rd/wr, a supported funct3, and natural alignment.
  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd && !wr) begin
      case (f3)
        LB, LBU: ok = 1'b1;
        LH, LHU: ok = ~off[0];
        LW:      ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else if (wr && !rd) begin
      case (f3)
        SB:      ok = 1'b1;
        SH:      ok = ~off[0];
        SW:      ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module  : load_extend
// Brief   : Selects the addressed byte/halfword of a read word and sign- or
//           zero-extends it according to the load funct3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           offset,
  input  logic [LSU_WIDTH-1:0] rdata,
  output logic [LSU_WIDTH-1:0] data
);

  logic [LSU_WIDTH-1:0] w_shift;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;

  always_comb begin
    w_shift = rdata >> {offset, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{w_byte[7]}}, w_byte};
      LH:      data = {{16{w_half[15]}}, w_half};
      LBU:     data = {24'd0, w_byte};
      LHU:     data = {16'd0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Brief   : Memory stage: issues byte/half/word loads and stores over a
//           valid/ready port, stalls while outstanding, flags illegal accesses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [2:0]           Funct3_i,
  input  logic [DATAWIDTH-1:0] ALUResult_i,
  input  logic [DATAWIDTH-1:0] WriteData_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [DATAWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic [DATAWIDTH-1:0] ReadData_o,
  output logic                 Stall_o,
  output logic                 Done_o,
  output logic                 Fault_o
);

  lsu_state_e           r_state;
  logic [DATAWIDTH-1:2] r_word_addr;
  logic [1:0]           r_offset;
  logic [2:0]           r_funct3;
  logic                 r_we;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [3:0]           r_be;
  logic                 r_fault;
  logic [DATAWIDTH-1:0] r_read_data;

  logic                 w_access;
  logic                 w_legal;
  logic [1:0]           w_off;
  logic [3:0]           w_be;
  logic [DATAWIDTH-1:0] w_wdata;
  logic [DATAWIDTH-1:0] w_ext;

  assign w_off    = ALUResult_i[1:0];
  assign w_access = MemRead_i | MemWrite_i;
  assign w_legal  = access_legal(MemRead_i, MemWrite_i, Funct3_i, w_off);

  // Lane placement for stores; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData_i;
    if (MemWrite_i) begin
      case (Funct3_i)
        SB: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{WriteData_i[7:0]}};
        end
        SH: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{WriteData_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = WriteData_i;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .funct3 (r_funct3),
    .offset (r_offset),
    .rdata  (mem_rdata_i),
    .data   (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word_addr <= '0;
      r_offset    <= 2'b00;
      r_funct3    <= 3'b000;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_be        <= 4'b0000;
      r_fault     <= 1'b0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_legal) begin
              r_word_addr <= ALUResult_i[DATAWIDTH-1:2];
              r_offset    <= w_off;
              r_funct3    <= Funct3_i;
              r_we        <= MemWrite_i;
              r_wdata     <= w_wdata;
              r_be        <= w_be;
              r_fault     <= 1'b0;
              r_state     <= REQ;
            end else begin
              r_fault <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            r_state <= r_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            r_read_data <= w_ext;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = (r_state == REQ);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = {r_word_addr, 2'b00};
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign ReadData_o  = r_read_data;
  assign Done_o      = (r_state == DONE);
  assign Fault_o     = (r_state == DONE) & r_fault;

  // Gated by rst so every output reads 0 while reset is held.
  assign Stall_o = ~rst & ((r_state == REQ) | (r_state == WAIT) |
                           ((r_state == IDLE) & w_access));

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Brief   : Scoreboard-driven bench for load_store_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  Funct3_i;
  logic [31:0] ALUResult_i;
  logic [31:0] WriteData_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ReadData_o;
  logic        Stall_o;
  logic        Done_o;
  logic        Fault_o;

  load_store_unit #(.DATAWIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Funct3_i     (Funct3_i),
    .ALUResult_i  (ALUResult_i),
    .WriteData_i  (WriteData_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .ReadData_o   (ReadData_o),
    .Stall_o      (Stall_o),
    .Done_o       (Done_o),
    .Fault_o      (Fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] rd;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors;
  int          miscompares;
  logic [31:0] exp_rd;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[int'(off) * 8 +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Drives one access starting in an IDLE cycle; gnt/rvalid delays in cycles.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input bit exp_fault, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                            input int gnt_dly, input int rv_dly);
    int   gnt_cyc, rv_cyc, done_cyc;
    bit   done;
    exp_t e, got;
    gnt_cyc  = exp_fault ? -1 : 1 + gnt_dly;
    rv_cyc   = (exp_fault || !rd) ? -1 : gnt_cyc + 1 + rv_dly;
    done_cyc = exp_fault ? 1 : (rd ? rv_cyc + 1 : gnt_cyc + 1);
    if (rd && !wr && !exp_fault) exp_rd = exp_load;
    e.fault = exp_fault; e.rd = exp_rd; e.done_cyc = done_cyc;
    sb_q.push_back(e);
    MemRead_i = rd; MemWrite_i = wr; Funct3_i = f3;
    ALUResult_i = addr; WriteData_i = wdata;
    done = 1'b0;
    for (int c = 0; c <= done_cyc + 20; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) begin MemRead_i = 1'b0; MemWrite_i = 1'b0; end
      mem_gnt_i    = (c == gnt_cyc);
      mem_rvalid_i = (c == rv_cyc);
      mem_rdata_i  = (c == rv_cyc) ? rdata : ~rdata;
      @(negedge clk);
      vectors++;
      if (Stall_o !== 1'(c < done_cyc)) begin
        miscompares++;
        $display("FAIL %s stall c=%0d: got %b exp %b", name, c, Stall_o, (c < done_cyc));
      end
      vectors++;
      if (mem_req_o !== 1'(c >= 1 && c <= gnt_cyc)) begin
        miscompares++;
        $display("FAIL %s req c=%0d: got %b exp %b", name, c, mem_req_o,
                 (c >= 1 && c <= gnt_cyc));
      end
      if (mem_req_o === 1'b1) begin
        vectors++;
        if (mem_addr_o !== {addr[31:2], 2'b00} || mem_we_o !== wr ||
            mem_be_o !== exp_be || (wr && mem_wdata_o !== exp_wdata)) begin
          miscompares++;
          $display("FAIL %s reqfields c=%0d: got a=%h we=%b be=%b wd=%h exp a=%h we=%b be=%b wd=%h",
                   name, c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
                   {addr[31:2], 2'b00}, wr, exp_be, exp_wdata);
        end
      end
      if (Done_o === 1'b1) begin
        got = sb_q.pop_front();
        vectors++;
        if (c != got.done_cyc || Fault_o !== got.fault || ReadData_o !== got.rd) begin
          miscompares++;
          $display("FAIL %s done: got cyc=%0d fault=%b rd=%h exp cyc=%0d fault=%b rd=%h",
                   name, c, Fault_o, ReadData_o, got.done_cyc, got.fault, got.rd);
        end
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      miscompares++;
      vectors++;
      $display("FAIL %s timeout: got no Done exp Done at cycle %0d", name, done_cyc);
      sb_q.delete();
    end
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({mem_req_o, mem_we_o, mem_be_o, Stall_o, Done_o, Fault_o} !== 9'd0 ||
        mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0 || ReadData_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: got req=%b we=%b be=%b st=%b dn=%b ft=%b a=%h wd=%h rd=%h exp all 0",
               mem_req_o, mem_we_o, mem_be_o, Stall_o, Done_o, Fault_o,
               mem_addr_o, mem_wdata_o, ReadData_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    run_access("sw_100", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 0, 0, 0);
    run_access("sb_103", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 4'b1000, 32'hA5A5A5A5, 0, 0, 0);
    run_access("sh_102", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 4'b1100, 32'hABCDABCD, 0, 1, 0);
    run_access("sb_101", 0, 1, 3'b000, 32'h101, 32'h0000003C, 0, 0, 4'b0010, 32'h3C3C3C3C, 0, 0, 0);
  endtask

  task automatic test_load_extend();
    run_access("lb_202",  1, 0, 3'b000, 32'h202, 0, 32'h12F03456, 0, 4'b1111, 0, 32'hFFFFFFF0, 0, 0);
    run_access("lbu_202", 1, 0, 3'b100, 32'h202, 0, 32'h12F03456, 0, 4'b1111, 0, 32'h000000F0, 0, 0);
    run_access("lhu_202", 1, 0, 3'b101, 32'h202, 0, 32'h12F03456, 0, 4'b1111, 0, 32'h000012F0, 0, 0);
    run_access("lh_200",  1, 0, 3'b001, 32'h200, 0, 32'h12F0B456, 0, 4'b1111, 0, 32'hFFFFB456, 0, 0);
    run_access("lw_300",  1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 0, 4'b1111, 0, 32'hCAFEF00D, 3, 1);
  endtask

  task automatic test_fault();
    run_access("lh_101",  1, 0, 3'b001, 32'h101, 0, 32'h11111111, 1, 4'b1111, 0, 0, 0, 0);
    run_access("sw_102",  0, 1, 3'b010, 32'h102, 32'h55, 0, 1, 4'b1111, 0, 0, 0, 0);
    run_access("ld_f011", 1, 0, 3'b011, 32'h100, 0, 32'h22222222, 1, 4'b1111, 0, 0, 0, 0);
    run_access("st_f100", 0, 1, 3'b100, 32'h100, 32'h77, 0, 1, 4'b1111, 0, 0, 0, 0);
    run_access("rd_wr",   1, 1, 3'b000, 32'h100, 32'h77, 0, 1, 4'b1111, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [31:0] addr, w, bdat;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    for (int i = 0; i < 8; i++) begin
      f3   = f3s[$urandom_range(0, 4)];
      addr = $urandom & 32'hFFFF_FFFC;
      if (f3[1:0] == 2'b00) addr[1:0] = 2'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) addr[1] = 1'($urandom_range(0, 1));
      w = $urandom;
      run_access("rand_load", 1, 0, f3, addr, 0, w, 0, 4'b1111, 0,
                 ref_load(f3, addr[1:0], w), $urandom_range(0, 2), $urandom_range(0, 2));
      addr = $urandom;
      bdat = $urandom;
      run_access("rand_sb", 0, 1, 3'b000, addr, bdat, 0, 0, 4'b0001 << addr[1:0],
                 {4{bdat[7:0]}}, 0, $urandom_range(0, 2), 0);
    end
  endtask

  task automatic test_reset_in_wait();
    MemRead_i = 1'b1; MemWrite_i = 1'b0; Funct3_i = 3'b010; ALUResult_i = 32'h400;
    @(posedge clk); #1;
    MemRead_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_req_o, mem_we_o, mem_be_o, Stall_o, Done_o, Fault_o} !== 9'd0 ||
        mem_addr_o !== 32'd0 || ReadData_o !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_wait: got req=%b be=%b st=%b dn=%b a=%h rd=%h exp all 0",
               mem_req_o, mem_be_o, Stall_o, Done_o, mem_addr_o, ReadData_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = 32'd0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h89ABCDEF;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ReadData_o !== 32'd0 || Done_o !== 1'b0 || Stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rvalid: got rd=%h dn=%b st=%b exp rd=0 dn=0 st=0",
               ReadData_o, Done_o, Stall_o);
    end
    @(posedge clk); #1;
    run_access("post_rst_sw", 0, 1, 3'b010, 32'h500, 32'h0BADF00D, 0, 0, 4'b1111,
               32'h0BADF00D, 0, 0, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_rd = 32'd0;
    rst = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0; Funct3_i = 3'b000;
    ALUResult_i = 32'd0; WriteData_i = 32'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    test_reset();
    test_store();
    test_load_extend();
    test_fault();
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
